comp_link_monitor: RTL and testbench
====================================

Name: comp_link_monitor

Overview:
- Downstream consumer of the comparator fiber receiver in the 160 MHz recovered-clock domain.
- Evaluates each received 48-bit frame using the receiver's PRBS check flags and sync monitor, and runs a link-state machine (DOWN/ACQ/UP).
- Keeps frame, error and link-drop counters.
- Measures round-trip latency from a local test trigger to the returned latency-trigger frame.

Parameters:
LOCK_FRAMES, 16, consecutive good frames in ACQ required to enter UP (1..255)
ERR_FRAMES, 4, consecutive bad frames in UP that drop the link to ACQ (1..15)
WDOG_CYCLES, 8, clocks without FRAME_CE before a frame is declared missing (5..63)
LAT_MAX, 4095, latency timeout in clocks (fits 12 bits)

Ports:
CMP_RX_CLK160  in  1  recovered 160 MHz clock
RST_N  in  1  synchronous reset, active-low
RX_SYNC_DONE  in  1  receiver phase alignment complete
FRAME_CE  in  1  one-cycle pulse; RCV_DATA/flags valid this cycle (receiver CEW0 strobe)
RCV_DATA  in  48  received frame
VALID  in  1  PRBS checker valid
MATCH  in  1  PRBS checker match
SYNCLOST  in  1  per-cycle sync error from receiver
NONZERO_WORD  in  3  per-word nonzero flags
LTNCY_TRIG  in  1  frame carried latency-trigger K-char
LAT_START  in  1  one-cycle pulse: latency measurement begins
CNT_CLR  in  1  synchronous clear of all counters
LINK_STATE  out  2  0=DOWN 1=ACQ 2=UP
LINK_UP  out  1  LINK_STATE==UP
FRAME_BAD  out  1  one-cycle pulse, frame judged bad
FRAME_CNT  out  32  frames evaluated, wraps
ERR_CNT  out  16  bad frames while UP, saturating
DROP_CNT  out  8  UP->ACQ/DOWN transitions, saturating
LAT_VALUE  out  12  last measured latency in clocks
LAT_DONE  out  1  latency measured, held until next LAT_START
LAT_TIMEOUT  out  1  measurement expired, held until next LAT_START

Behaviour:
- Reset (RST_N=0 at clock edge): all outputs 0, LINK_STATE=DOWN, internal counters and sticky flags 0.
- Frame evaluation occurs on FRAME_CE cycles or on a watchdog expiry.
- Sticky sync_err:
  - Set by SYNCLOST on any cycle.
  - Cleared on each evaluation, then re-seeded with SYNCLOST of that same cycle.
- A frame is bad if any of:
  - VALID=1 and MATCH=0;
  - VALID=0 in UP;
  - sync_err or SYNCLOST set;
  - watchdog expiry.
- Watchdog:
  - Cycle counter reset by FRAME_CE; expires when it reaches WDOG_CYCLES, then restarts.
  - Expiry evaluates a bad frame.
  - Inactive in DOWN.
- Registered outputs lag evaluation by 1 clock:
  - FRAME_BAD pulses 1 clock after the evaluation cycle.
  - FRAME_CNT increments 1 clock after each evaluation (not in DOWN).
- State machine (next state registered, 1-clock latency):
  - DOWN: go to ACQ when RX_SYNC_DONE=1.
  - ACQ: good frame increments good_run, bad frame zeroes it; good_run==LOCK_FRAMES -> UP and good_run=0.
  - UP: bad frame increments bad_run and ERR_CNT; good frame zeroes bad_run; bad_run==ERR_FRAMES -> ACQ, DROP_CNT+1.
  - Any state: RX_SYNC_DONE=0 -> DOWN and run counters zeroed. If the link was UP, DROP_CNT+1.
- Counters:
  - ERR_CNT holds at 0xFFFF; DROP_CNT holds at 0xFF.
  - CNT_CLR has priority over same-cycle increments; result is 0.
  - CNT_CLR does not affect state or latency.
- Latency:
  - LAT_START clears LAT_DONE, LAT_TIMEOUT and LAT_VALUE, zeroes lat_cnt, and arms the measurement.
  - While armed, lat_cnt increments each clock.
  - Arrival = FRAME_CE & LTNCY_TRIG while armed: LAT_VALUE=lat_cnt+1, LAT_DONE=1, disarm.
  - lat_cnt reaching LAT_MAX: LAT_TIMEOUT=1, LAT_VALUE=LAT_MAX, disarm.
  - LAT_START coincident with arrival: restart wins.
  - LTNCY_TRIG while not armed is ignored.
- RCV_DATA is not checked except by the optional feature.
- Reset mid-measurement aborts it with no DONE and no TIMEOUT.

Optional Feature:
- CMP_LINK_NONZERO_CHECK_EN defined: in UP, a frame with NONZERO_WORD==3'b000 and RCV_DATA==0 on FRAME_CE is also bad (stuck-zero link detection).
- Not defined: NONZERO_WORD and RCV_DATA are ignored and no logic is generated.

Test Plan:
- Power-on and lock: RST_N low 4 clocks, then RX_SYNC_DONE=1, FRAME_CE every 4 clocks, VALID=MATCH=1.
  - LINK_STATE 0->1, then 2 after the 16th good frame (+1 clock).
  - FRAME_CNT=16 at lock; ERR_CNT=0.
- Link drop: in UP, MATCH=0 for 4 consecutive frames.
  - ERR_CNT=4, DROP_CNT=1, LINK_STATE=ACQ.
  - Only 3 bad frames then good: stays UP with ERR_CNT=3.
- Watchdog: in UP, stop FRAME_CE.
  - FRAME_BAD pulses every 8 clocks.
  - Link falls to ACQ after 4 expiries; DROP_CNT=1.
- Sync loss: SYNCLOST single-cycle pulse between strobes.
  - Next frame is bad, ERR_CNT+1; the following frame is good.
  - RX_SYNC_DONE=0 in UP -> DOWN next clock, DROP_CNT+1.
- Latency: LAT_START, then LTNCY_TRIG with FRAME_CE 37 clocks later -> LAT_VALUE=37, LAT_DONE=1.
  - No trigger: LAT_TIMEOUT=1 after 4095 clocks, LAT_VALUE=4095.
- Counter clear and saturation:
  - Force ERR_CNT to 0xFFFF; one more bad frame -> still 0xFFFF.
  - CNT_CLR coincident with a bad frame -> ERR_CNT=0.

Source files
------------

// File: rtl/comp_link_monitor.sv
// comp_link_monitor: judges each frame from the comparator fiber receiver,
// tracks link state (DOWN/ACQ/UP), keeps frame/error/drop counters and
// measures round-trip latency to the returned latency-trigger frame.
// Optional build macro: CMP_LINK_NONZERO_CHECK_EN adds stuck-zero detection
// of all-zero frames while the link is UP.
module comp_link_monitor #(
  parameter int LOCK_FRAMES = 16,
  parameter int ERR_FRAMES  = 4,
  parameter int WDOG_CYCLES = 8,
  parameter int LAT_MAX     = 4095
) (
  input  logic        CMP_RX_CLK160,
  input  logic        RST_N,
  input  logic        RX_SYNC_DONE,
  input  logic        FRAME_CE,
  input  logic [47:0] RCV_DATA,
  input  logic        VALID,
  input  logic        MATCH,
  input  logic        SYNCLOST,
  input  logic [2:0]  NONZERO_WORD,
  input  logic        LTNCY_TRIG,
  input  logic        LAT_START,
  input  logic        CNT_CLR,
  output logic [1:0]  LINK_STATE,
  output logic        LINK_UP,
  output logic        FRAME_BAD,
  output logic [31:0] FRAME_CNT,
  output logic [15:0] ERR_CNT,
  output logic [7:0]  DROP_CNT,
  output logic [11:0] LAT_VALUE,
  output logic        LAT_DONE,
  output logic        LAT_TIMEOUT
);

  typedef enum logic [1:0] {
    ST_DOWN = 2'd0,
    ST_ACQ  = 2'd1,
    ST_UP   = 2'd2
  } link_state_t;

  link_state_t state, state_nxt;
  logic [7:0]  good_run, good_run_nxt;
  logic [3:0]  bad_run, bad_run_nxt;
  logic        drop_inc;
  logic [5:0]  wdog_cnt;
  logic        wdog_exp;
  logic        sync_err;
  logic        eval;
  logic        frame_bad_c;
  logic        zero_bad;
  logic        err_inc;
  logic [31:0] frame_cnt;
  logic [15:0] err_cnt;
  logic [7:0]  drop_cnt;
  logic        frame_bad_q;
  logic        lat_armed;
  logic [11:0] lat_cnt;
  logic [11:0] lat_value;
  logic        lat_done;
  logic        lat_timeout;

  // A missing strobe counts as a bad frame once WDOG_CYCLES idle clocks pass
  assign wdog_exp = (state != ST_DOWN) && !FRAME_CE && (wdog_cnt == 6'(WDOG_CYCLES - 1));
  assign eval     = (state != ST_DOWN) && (FRAME_CE || wdog_exp);

`ifdef CMP_LINK_NONZERO_CHECK_EN
  assign zero_bad = (state == ST_UP) && FRAME_CE && (NONZERO_WORD == 3'b000) && (RCV_DATA == 48'd0);
`else
  logic unused_frame_bits;
  assign unused_frame_bits = ^{NONZERO_WORD, RCV_DATA};
  assign zero_bad = 1'b0;
`endif

  assign frame_bad_c = (VALID && !MATCH) || (!VALID && (state == ST_UP)) ||
                       sync_err || SYNCLOST || wdog_exp || zero_bad;
  assign err_inc     = eval && frame_bad_c && (state == ST_UP);

  // Watchdog counts idle clocks since the last strobe, restarting on expiry
  always_ff @(posedge CMP_RX_CLK160) begin
    if (!RST_N)
      wdog_cnt <= '0;
    else if ((state == ST_DOWN) || FRAME_CE || wdog_exp)
      wdog_cnt <= '0;
    else
      wdog_cnt <= wdog_cnt + 6'd1;
  end

  // Sticky sync error: remembers SYNCLOST between evaluations
  always_ff @(posedge CMP_RX_CLK160) begin
    if (!RST_N)
      sync_err <= 1'b0;
    else if (eval)
      sync_err <= SYNCLOST;
    else if (SYNCLOST)
      sync_err <= 1'b1;
  end

  // Link FSM state and run-length registers
  always_ff @(posedge CMP_RX_CLK160) begin
    if (!RST_N) begin
      state    <= ST_DOWN;
      good_run <= '0;
      bad_run  <= '0;
    end else begin
      state    <= state_nxt;
      good_run <= good_run_nxt;
      bad_run  <= bad_run_nxt;
    end
  end

  // Link FSM next state, run counters and drop event
  always_comb begin
    state_nxt    = state;
    good_run_nxt = good_run;
    bad_run_nxt  = bad_run;
    drop_inc     = 1'b0;
    if (!RX_SYNC_DONE) begin
      state_nxt    = ST_DOWN;
      good_run_nxt = '0;
      bad_run_nxt  = '0;
      drop_inc     = (state == ST_UP);
    end else begin
      case (state)
        ST_DOWN: state_nxt = ST_ACQ;
        ST_ACQ: begin
          if (eval) begin
            if (frame_bad_c) begin
              good_run_nxt = '0;
            end else if (good_run == 8'(LOCK_FRAMES - 1)) begin
              state_nxt    = ST_UP;
              good_run_nxt = '0;
            end else begin
              good_run_nxt = good_run + 8'd1;
            end
          end
        end
        ST_UP: begin
          if (eval) begin
            if (!frame_bad_c) begin
              bad_run_nxt = '0;
            end else if (bad_run == 4'(ERR_FRAMES - 1)) begin
              state_nxt   = ST_ACQ;
              bad_run_nxt = '0;
              drop_inc    = 1'b1;
            end else begin
              bad_run_nxt = bad_run + 4'd1;
            end
          end
        end
        default: state_nxt = ST_DOWN;
      endcase
    end
  end

  // Statistics counters; a clear beats any same-cycle increment
  always_ff @(posedge CMP_RX_CLK160) begin
    if (!RST_N || CNT_CLR) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
      drop_cnt  <= '0;
    end else begin
      if (eval)
        frame_cnt <= frame_cnt + 32'd1;
      if (err_inc && (err_cnt != 16'hFFFF))
        err_cnt <= err_cnt + 16'd1;
      if (drop_inc && (drop_cnt != 8'hFF))
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // One-clock bad-frame pulse following each evaluation
  always_ff @(posedge CMP_RX_CLK160) begin
    if (!RST_N)
      frame_bad_q <= 1'b0;
    else
      frame_bad_q <= eval && frame_bad_c;
  end

  // Latency measurement: a new start always restarts, arrival beats timeout
  always_ff @(posedge CMP_RX_CLK160) begin
    if (!RST_N) begin
      lat_armed   <= 1'b0;
      lat_cnt     <= '0;
      lat_value   <= '0;
      lat_done    <= 1'b0;
      lat_timeout <= 1'b0;
    end else if (LAT_START) begin
      lat_armed   <= 1'b1;
      lat_cnt     <= '0;
      lat_value   <= '0;
      lat_done    <= 1'b0;
      lat_timeout <= 1'b0;
    end else if (lat_armed) begin
      lat_cnt <= lat_cnt + 12'd1;
      if (FRAME_CE && LTNCY_TRIG) begin
        lat_value <= lat_cnt + 12'd1;
        lat_done  <= 1'b1;
        lat_armed <= 1'b0;
      end else if (lat_cnt == 12'(LAT_MAX - 1)) begin
        lat_value   <= 12'(LAT_MAX);
        lat_timeout <= 1'b1;
        lat_armed   <= 1'b0;
      end
    end
  end

  assign LINK_STATE  = state;
  assign LINK_UP     = (state == ST_UP);
  assign FRAME_BAD   = frame_bad_q;
  assign FRAME_CNT   = frame_cnt;
  assign ERR_CNT     = err_cnt;
  assign DROP_CNT    = drop_cnt;
  assign LAT_VALUE   = lat_value;
  assign LAT_DONE    = lat_done;
  assign LAT_TIMEOUT = lat_timeout;

endmodule

// File: tb/tb_comp_link_monitor.sv
// Testbench for comp_link_monitor: expected frame verdicts and latency
// values are queued when stimulus is driven and compared when the DUT
// presents its registered outputs.
module tb_comp_link_monitor;

  logic        clk = 1'b0;
  logic        rst_n, rx_sync_done, frame_ce, valid, match, synclost;
  logic        ltncy_trig, lat_start, cnt_clr;
  logic [47:0] rcv_data;
  logic [2:0]  nonzero_word;
  logic [1:0]  link_state;
  logic        link_up, frame_bad, lat_done, lat_timeout;
  logic [31:0] frame_cnt;
  logic [15:0] err_cnt;
  logic [7:0]  drop_cnt;
  logic [11:0] lat_value;

  int          checks = 0;
  int          errors = 0;
  int          exp_frames = 0;
  logic        bad_q[$];
  logic [11:0] lat_q[$];
  logic        exp_b;
  logic [11:0] exp_lat;

  comp_link_monitor dut (
    .CMP_RX_CLK160(clk),
    .RST_N(rst_n),
    .RX_SYNC_DONE(rx_sync_done),
    .FRAME_CE(frame_ce),
    .RCV_DATA(rcv_data),
    .VALID(valid),
    .MATCH(match),
    .SYNCLOST(synclost),
    .NONZERO_WORD(nonzero_word),
    .LTNCY_TRIG(ltncy_trig),
    .LAT_START(lat_start),
    .CNT_CLR(cnt_clr),
    .LINK_STATE(link_state),
    .LINK_UP(link_up),
    .FRAME_BAD(frame_bad),
    .FRAME_CNT(frame_cnt),
    .ERR_CNT(err_cnt),
    .DROP_CNT(drop_cnt),
    .LAT_VALUE(lat_value),
    .LAT_DONE(lat_done),
    .LAT_TIMEOUT(lat_timeout)
  );

  // 160 MHz-style free-running clock
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls
  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish before 2 ms");
    $fatal(1, "[TB] stalled");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic pulse_frame(input logic v, input logic m);
    valid = v; match = m; frame_ce = 1'b1;
    exp_frames++;
    tick(1);
    frame_ce = 1'b0;
  endtask

  task automatic send_frame(input logic v, input logic m, input logic exp_bad);
    bad_q.push_back(exp_bad);
    pulse_frame(v, m);
  endtask

  task automatic do_lock();
    repeat (16) begin
      pulse_frame(1'b1, 1'b1);
      tick(3);
    end
  endtask

  task automatic pulse_clear();
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    exp_frames = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_sync_done = 1'b0; frame_ce = 1'b0; valid = 1'b0; match = 1'b0;
    synclost = 1'b0; ltncy_trig = 1'b0; lat_start = 1'b0; cnt_clr = 1'b0;
    rcv_data = 48'h0; nonzero_word = 3'b000;
    tick(4);
    checks++; if (link_state !== 2'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d expected 0", link_state); end
    checks++; if ({link_up, frame_bad, lat_done, lat_timeout} !== 4'b0) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 0000", {link_up, frame_bad, lat_done, lat_timeout}); end
    checks++; if ({frame_cnt, err_cnt, drop_cnt, lat_value} !== 68'h0) begin errors++; $display("[TB] FAIL reset_counters: got %0h expected 0", {frame_cnt, err_cnt, drop_cnt, lat_value}); end
  endtask

  task automatic test_lock();
    rst_n = 1'b1; rx_sync_done = 1'b1;
    tick(1);
    checks++; if (link_state !== 2'd1) begin errors++; $display("[TB] FAIL lock_enter_acq: got %0d expected 1", link_state); end
    for (int i = 1; i <= 16; i++) begin
      send_frame(1'b1, 1'b1, 1'b0);
      exp_b = bad_q.pop_front();
      checks++; if (frame_bad !== exp_b) begin errors++; $display("[TB] FAIL lock_frame_bad[%0d]: got %b expected %b", i, frame_bad, exp_b); end
      if (i == 15) begin
        checks++; if (link_state !== 2'd1) begin errors++; $display("[TB] FAIL lock_still_acq: got %0d expected 1", link_state); end
      end
      if (i == 16) begin
        checks++; if (link_state !== 2'd2 || link_up !== 1'b1) begin errors++; $display("[TB] FAIL lock_up: got %0d/%b expected 2/1", link_state, link_up); end
        checks++; if (frame_cnt !== 32'(exp_frames)) begin errors++; $display("[TB] FAIL lock_frame_cnt: got %0d expected %0d", frame_cnt, exp_frames); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("[TB] FAIL lock_err_cnt: got %0d expected 0", err_cnt); end
      end
      tick(3);
    end
  endtask

  task automatic test_link_drop();
    for (int i = 1; i <= 4; i++) begin
      send_frame(1'b1, 1'b0, 1'b1);
      exp_b = bad_q.pop_front();
      checks++; if (frame_bad !== exp_b) begin errors++; $display("[TB] FAIL drop_frame_bad[%0d]: got %b expected %b", i, frame_bad, exp_b); end
      if (i == 3) begin
        checks++; if (link_state !== 2'd2) begin errors++; $display("[TB] FAIL drop_hold_up: got %0d expected 2", link_state); end
      end
      tick(3);
    end
    checks++; if (link_state !== 2'd1) begin errors++; $display("[TB] FAIL drop_state: got %0d expected 1", link_state); end
    checks++; if (err_cnt !== 16'd4 || drop_cnt !== 8'd1) begin errors++; $display("[TB] FAIL drop_counts: got err %0d drop %0d expected err 4 drop 1", err_cnt, drop_cnt); end
    checks++; if (frame_cnt !== 32'(exp_frames)) begin errors++; $display("[TB] FAIL drop_frame_cnt: got %0d expected %0d", frame_cnt, exp_frames); end
    do_lock();
    pulse_clear();
    checks++; if (frame_cnt !== 32'd0 || link_state !== 2'd2) begin errors++; $display("[TB] FAIL clear_keeps_state: got cnt %0d state %0d expected cnt 0 state 2", frame_cnt, link_state); end
    for (int i = 1; i <= 4; i++) begin
      send_frame(1'b1, (i == 4), (i != 4));
      exp_b = bad_q.pop_front();
      checks++; if (frame_bad !== exp_b) begin errors++; $display("[TB] FAIL three_bad_frame[%0d]: got %b expected %b", i, frame_bad, exp_b); end
      tick(3);
    end
    checks++; if (link_state !== 2'd2 || err_cnt !== 16'd3 || drop_cnt !== 8'd0) begin errors++; $display("[TB] FAIL three_bad_hold: got state %0d err %0d drop %0d expected 2/3/0", link_state, err_cnt, drop_cnt); end
  endtask

  task automatic test_watchdog();
    pulse_clear();
    send_frame(1'b1, 1'b1, 1'b0);
    exp_b = bad_q.pop_front();
    checks++; if (frame_bad !== exp_b) begin errors++; $display("[TB] FAIL wdog_last_frame: got %b expected %b", frame_bad, exp_b); end
    for (int k = 1; k <= 32; k++) begin
      tick(1);
      bad_q.push_back((k % 8) == 0);
      if ((k % 8) == 0) exp_frames++;
      exp_b = bad_q.pop_front();
      checks++; if (frame_bad !== exp_b) begin errors++; $display("[TB] FAIL wdog_pulse[%0d]: got %b expected %b", k, frame_bad, exp_b); end
      if (k == 24) begin
        checks++; if (link_state !== 2'd2) begin errors++; $display("[TB] FAIL wdog_hold_up: got %0d expected 2", link_state); end
      end
    end
    checks++; if (link_state !== 2'd1 || drop_cnt !== 8'd1 || err_cnt !== 16'd4) begin errors++; $display("[TB] FAIL wdog_drop: got state %0d drop %0d err %0d expected 1/1/4", link_state, drop_cnt, err_cnt); end
    checks++; if (frame_cnt !== 32'(exp_frames)) begin errors++; $display("[TB] FAIL wdog_frame_cnt: got %0d expected %0d", frame_cnt, exp_frames); end
  endtask

  task automatic test_sync_loss();
    do_lock();
    pulse_clear();
    send_frame(1'b1, 1'b1, 1'b0);
    exp_b = bad_q.pop_front();
    checks++; if (frame_bad !== exp_b) begin errors++; $display("[TB] FAIL sync_pre_frame: got %b expected %b", frame_bad, exp_b); end
    synclost = 1'b1;
    tick(1);
    synclost = 1'b0;
    tick(2);
    send_frame(1'b1, 1'b1, 1'b1);
    exp_b = bad_q.pop_front();
    checks++; if (frame_bad !== exp_b) begin errors++; $display("[TB] FAIL sync_bad_frame: got %b expected %b", frame_bad, exp_b); end
    checks++; if (err_cnt !== 16'd1 || link_state !== 2'd2) begin errors++; $display("[TB] FAIL sync_err_cnt: got err %0d state %0d expected 1/2", err_cnt, link_state); end
    tick(3);
    send_frame(1'b1, 1'b1, 1'b0);
    exp_b = bad_q.pop_front();
    checks++; if (frame_bad !== exp_b) begin errors++; $display("[TB] FAIL sync_next_good: got %b expected %b", frame_bad, exp_b); end
    tick(3);
    rx_sync_done = 1'b0;
    tick(1);
    checks++; if (link_state !== 2'd0 || link_up !== 1'b0 || drop_cnt !== 8'd1) begin errors++; $display("[TB] FAIL sync_down: got state %0d up %b drop %0d expected 0/0/1", link_state, link_up, drop_cnt); end
  endtask

  task automatic test_latency();
    valid = 1'b1; match = 1'b1;
    ltncy_trig = 1'b1; frame_ce = 1'b1;
    tick(1);
    ltncy_trig = 1'b0; frame_ce = 1'b0;
    checks++; if (lat_done !== 1'b0 || lat_value !== 12'd0) begin errors++; $display("[TB] FAIL lat_unarmed: got done %b value %0d expected 0/0", lat_done, lat_value); end
    lat_start = 1'b1;
    tick(1);
    lat_start = 1'b0;
    tick(36);
    frame_ce = 1'b1; ltncy_trig = 1'b1;
    lat_q.push_back(12'd37);
    tick(1);
    frame_ce = 1'b0; ltncy_trig = 1'b0;
    exp_lat = lat_q.pop_front();
    checks++; if (lat_value !== exp_lat || lat_done !== 1'b1 || lat_timeout !== 1'b0) begin errors++; $display("[TB] FAIL lat_37: got value %0d done %b to %b expected %0d/1/0", lat_value, lat_done, lat_timeout, exp_lat); end
    checks++; if (frame_cnt !== 32'(exp_frames) || frame_bad !== 1'b0) begin errors++; $display("[TB] FAIL down_no_eval: got cnt %0d bad %b expected %0d/0", frame_cnt, frame_bad, exp_frames); end
    tick(2);
    frame_ce = 1'b1; ltncy_trig = 1'b1;
    tick(1);
    frame_ce = 1'b0; ltncy_trig = 1'b0;
    checks++; if (lat_value !== 12'd37 || lat_done !== 1'b1) begin errors++; $display("[TB] FAIL lat_hold: got %0d/%b expected 37/1", lat_value, lat_done); end
    lat_start = 1'b1;
    tick(1);
    lat_start = 1'b0;
    checks++; if (lat_done !== 1'b0 || lat_value !== 12'd0) begin errors++; $display("[TB] FAIL lat_start_clears: got %b/%0d expected 0/0", lat_done, lat_value); end
    tick(8);
    lat_start = 1'b1; frame_ce = 1'b1; ltncy_trig = 1'b1;
    tick(1);
    lat_start = 1'b0; frame_ce = 1'b0; ltncy_trig = 1'b0;
    checks++; if (lat_done !== 1'b0 || lat_value !== 12'd0) begin errors++; $display("[TB] FAIL lat_restart_wins: got %b/%0d expected 0/0", lat_done, lat_value); end
    tick(4);
    frame_ce = 1'b1; ltncy_trig = 1'b1;
    lat_q.push_back(12'd5);
    tick(1);
    frame_ce = 1'b0; ltncy_trig = 1'b0;
    exp_lat = lat_q.pop_front();
    checks++; if (lat_value !== exp_lat || lat_done !== 1'b1) begin errors++; $display("[TB] FAIL lat_after_restart: got %0d/%b expected %0d/1", lat_value, lat_done, exp_lat); end
    lat_start = 1'b1;
    tick(1);
    lat_start = 1'b0;
    lat_q.push_back(12'd4095);
    tick(4094);
    checks++; if (lat_timeout !== 1'b0 || lat_done !== 1'b0) begin errors++; $display("[TB] FAIL lat_early_timeout: got to %b done %b expected 0/0", lat_timeout, lat_done); end
    tick(1);
    exp_lat = lat_q.pop_front();
    checks++; if (lat_timeout !== 1'b1 || lat_value !== exp_lat || lat_done !== 1'b0) begin errors++; $display("[TB] FAIL lat_timeout: got to %b value %0d done %b expected 1/%0d/0", lat_timeout, lat_value, lat_done, exp_lat); end
    lat_start = 1'b1;
    tick(1);
    lat_start = 1'b0;
    tick(10);
    rst_n = 1'b0;
    tick(1);
    exp_frames = 0;
    checks++; if ({lat_done, lat_timeout} !== 2'b00 || lat_value !== 12'd0) begin errors++; $display("[TB] FAIL lat_reset_abort: got %b/%b/%0d expected 0/0/0", lat_done, lat_timeout, lat_value); end
    rst_n = 1'b1;
    tick(5);
    frame_ce = 1'b1; ltncy_trig = 1'b1;
    tick(1);
    frame_ce = 1'b0; ltncy_trig = 1'b0;
    checks++; if (lat_done !== 1'b0) begin errors++; $display("[TB] FAIL lat_disarmed_after_reset: got %b expected 0", lat_done); end
  endtask

  task automatic test_counters();
    rx_sync_done = 1'b1;
    tick(1);
    do_lock();
    force dut.err_cnt = 16'hFFFF;
    tick(1);
    release dut.err_cnt;
    send_frame(1'b1, 1'b0, 1'b1);
    exp_b = bad_q.pop_front();
    checks++; if (frame_bad !== exp_b) begin errors++; $display("[TB] FAIL sat_frame_bad: got %b expected %b", frame_bad, exp_b); end
    checks++; if (err_cnt !== 16'hFFFF) begin errors++; $display("[TB] FAIL err_saturate: got %0h expected ffff", err_cnt); end
    checks++; if (frame_cnt !== 32'(exp_frames)) begin errors++; $display("[TB] FAIL sat_frame_cnt: got %0d expected %0d", frame_cnt, exp_frames); end
    tick(3);
    cnt_clr = 1'b1;
    send_frame(1'b1, 1'b0, 1'b1);
    cnt_clr = 1'b0;
    exp_frames = 0;
    exp_b = bad_q.pop_front();
    checks++; if (frame_bad !== exp_b) begin errors++; $display("[TB] FAIL clr_frame_bad: got %b expected %b", frame_bad, exp_b); end
    checks++; if (err_cnt !== 16'd0 || frame_cnt !== 32'(exp_frames) || link_state !== 2'd2) begin errors++; $display("[TB] FAIL clr_priority: got err %0d cnt %0d state %0d expected 0/0/2", err_cnt, frame_cnt, link_state); end
  endtask

  // Test sequence
  initial begin
    test_reset();
    test_lock();
    test_link_drop();
    test_watchdog();
    test_sync_loss();
    test_latency();
    test_counters();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
